// File: rtl/div.sv
// Unsigned restoring divider: one quotient bit per SHIFT/SUB pair, N_DVD
// iterations. Divide-by-zero is caught in LOAD and returns all-ones/zero.
//
// Handshake: init is a level request sampled only in IDLE. done is a level
// that stays high in DONE for as long as init stays high. Dropping init in
// DONE returns the block to IDLE one edge later, and a new request is
// accepted on the edge after that. quot, rem and dz are valid whenever done=1
// and keep their values until the next capture.
module div #(
  parameter int N_DVD = 6,
  parameter int N_DVR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [N_DVD-1:0] DV,
  input  logic [N_DVR-1:0] DR,
  output logic             done,
  output logic [N_DVD-1:0] quot,
  output logic [N_DVR-1:0] rem,
  output logic             dz,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(N_DVD + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [N_DVR:0]   a;     // partial remainder, one guard bit for the sign
  logic [N_DVD-1:0] q;     // dividend shifting out, quotient shifting in
  logic [N_DVR-1:0] d;     // captured divisor
  logic [CW-1:0]    cnt;   // completed iterations

  logic [N_DVR:0]   diff;
  logic [N_DVR:0]   a_sub;
  logic [N_DVD-1:0] q_sub;
  logic [CW-1:0]    cnt_nxt;
  logic             last_iter;

  // Trial subtraction and the register values SUB would commit; computed here
  // so the final iteration can load the outputs with its own quotient bit.
  always_comb begin
    diff      = a - {1'b0, d};
    a_sub     = a;
    q_sub     = q;
    if (!diff[N_DVR]) begin
      a_sub = diff;
      q_sub = {q[N_DVD-1:1], 1'b1};
    end
    cnt_nxt   = cnt + CW'(1);
    last_iter = (cnt_nxt == CW'(N_DVD));
  end

  assign dbg_state = state;

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      dz    <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            q     <= DV;
            d     <= DR;
            a     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (d == '0) begin
            dz    <= 1'b1;
            quot  <= '1;
            rem   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {a, q} <= {a[N_DVR-1:0], q, 1'b0};
          state  <= SUB;
        end
        SUB: begin
          a   <= a_sub;
          q   <= q_sub;
          cnt <= cnt_nxt;
          if (last_iter) begin
            quot  <= q_sub;
            rem   <= a_sub[N_DVR-1:0];
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          if (!init) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
